// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with registered read data and one-cycle error pulses
// for writes into a full FIFO and reads from an empty one.
module sync_fifo_core #(
  parameter int FIFO_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic                  full,
  output logic                  wr_err,
  output logic                  empty,
  output logic                  rd_err,
  output logic [FIFO_WIDTH-1:0] rd_data
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A read in the same cycle frees the slot, so a write into a full FIFO
  // is only rejected when no read accompanies it.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_en);

  // Storage is deliberately not reset; pointers alone define valid data.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      rd_err <= rd_en && empty;

      if (wr_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);

      if (rd_ok) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
      end else if (rd_en) begin
        rd_data <= '0;
      end

      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Directed self-checking bench for sync_fifo_core: overflow/underflow,
// simultaneous access at empty/mid/full, and asynchronous reset.
module tb_sync_fifo_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         rd_en;
  logic         full;
  logic         wr_err;
  logic         empty;
  logic         rd_err;
  logic [W-1:0] rd_data;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  sync_fifo_core #(.FIFO_WIDTH(W), .ADDR_WIDTH(3), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .full(full), .wr_err(wr_err), .empty(empty), .rd_err(rd_err), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus at the falling edge; return 1 ns after the
  // following rising edge so outputs can be sampled.
  task automatic cycle(input logic w, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err); end
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL reset_rd_err got=%b exp=0", rd_err); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, W'(i), 1'b0);
      if (i <= 8) exp_q.push_back(W'(i));
      checks++;
      if (full !== (i >= 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i >= 8)); end
      checks++;
      if (wr_err !== (i > 8)) begin failures++; $display("FAIL fill_wr_err[%0d] got=%b exp=%b", i, wr_err, (i > 8)); end
      checks++;
      if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
    end
    cycle(1'b0, '0, 1'b0);
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_pulse got=%b exp=0", wr_err); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_hold got=%b exp=1", full); end
  endtask

  task automatic test_drain_underflow();
    logic [W-1:0] exp;
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, '0, 1'b1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      checks++;
      if (rd_data !== exp) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, exp); end
      checks++;
      if (rd_err !== (i > 8)) begin failures++; $display("FAIL drain_rd_err[%0d] got=%b exp=%b", i, rd_err, (i > 8)); end
      checks++;
      if (empty !== (i >= 8)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i >= 8)); end
    end
    cycle(1'b0, '0, 1'b0);
    checks++; if (rd_err !== 1'b0) begin failures++; $display("FAIL rd_err_pulse got=%b exp=0", rd_err); end
  endtask

  task automatic test_rd_hold();
    cycle(1'b1, 32'h0000_00C3, 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 32'h0000_00C3) begin failures++; $display("FAIL hold_read got=%h exp=000000c3", rd_data); end
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);
    checks++; if (rd_data !== 32'h0000_00C3) begin failures++; $display("FAIL hold_idle got=%h exp=000000c3", rd_data); end
  endtask

  task automatic test_full_simul();
    logic [W-1:0] exp;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, W'(32'h10 + i), 1'b0);
      exp_q.push_back(W'(32'h10 + i));
    end
    cycle(1'b1, 32'h0000_0018, 1'b1);
    exp = exp_q.pop_front();
    exp_q.push_back(32'h0000_0018);
    checks++; if (rd_data !== exp) begin failures++; $display("FAIL full_simul_data got=%h exp=%h", rd_data, exp); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL full_simul_full got=%b exp=1", full); end
    checks++; if (wr_err !== 1'b0) begin failures++; $display("FAIL full_simul_wr_err got=%b exp=0", wr_err); end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, '0, 1'b1);
      exp = exp_q.pop_front();
      checks++;
      if (rd_data !== exp) begin failures++; $display("FAIL full_simul_drain[%0d] got=%h exp=%h", i, rd_data, exp); end
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL full_simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_empty_simul();
    cycle(1'b1, 32'h0000_00A5, 1'b1);
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL empty_simul_rd_err got=%b exp=1", rd_err); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL empty_simul_data got=%h exp=0", rd_data); end
    checks++; if (empty !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL empty_simul_count got empty=%b full=%b exp empty=0 full=0", empty, full); end
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 32'h0000_00A5) begin failures++; $display("FAIL empty_simul_read got=%h exp=000000a5", rd_data); end
    checks++; if (empty !== 1'b1 || rd_err !== 1'b0) begin failures++; $display("FAIL empty_simul_after got empty=%b rd_err=%b exp empty=1 rd_err=0", empty, rd_err); end
  endtask

  task automatic test_mid_simul();
    cycle(1'b1, 32'h1111_1111, 1'b0);
    cycle(1'b1, 32'h2222_2222, 1'b0);
    cycle(1'b1, 32'h3333_3333, 1'b1);
    checks++; if (rd_data !== 32'h1111_1111) begin failures++; $display("FAIL mid_simul_data got=%h exp=11111111", rd_data); end
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 32'h2222_2222) begin failures++; $display("FAIL mid_simul_rd2 got=%h exp=22222222", rd_data); end
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 32'h3333_3333) begin failures++; $display("FAIL mid_simul_rd3 got=%h exp=33333333", rd_data); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL mid_simul_empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'h40 + i), 1'b0);
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_data !== 32'h0000_0040) begin failures++; $display("FAIL pre_reset_read got=%h exp=00000040", rd_data); end
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL async_reset_empty got=%b exp=1", empty); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL async_reset_data got=%h exp=0", rd_data); end
    @(negedge clk);
    rst_n = 1'b0;
    cycle(1'b0, '0, 1'b1);
    checks++; if (rd_err !== 1'b1) begin failures++; $display("FAIL post_reset_rd_err got=%b exp=1", rd_err); end
    checks++; if (rd_data !== '0) begin failures++; $display("FAIL post_reset_data got=%h exp=0", rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_rd_hold();
    test_full_simul();
    test_empty_simul();
    test_mid_simul();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_core.md
SYNC_FIFO_CORE -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, storage address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, number of entries, equal to 2**ADDR_WIDTH.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-high reset (name kept per codebase convention; 1 = reset asserted).
REQ-006 SHALL have port wr_en, input, 1, write request for the current cycle.
REQ-007 SHALL have port wr_data, input, FIFO_WIDTH, data to write.
REQ-008 SHALL have port rd_en, input, 1, read request for the current cycle.
REQ-009 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH entries.
REQ-010 SHALL have port wr_err, output, 1, registered flag marking a rejected write.
REQ-011 SHALL have port empty, output, 1, FIFO holds 0 entries.
REQ-012 SHALL have port rd_err, output, 1, registered flag marking a rejected read.
REQ-013 SHALL have port rd_data, output, FIFO_WIDTH, registered read data.

Function
REQ-014 SHALL store up to FIFO_DEPTH words in first-in-first-out order.
REQ-015 SHALL track occupancy with write pointer, read pointer and a count of width ADDR_WIDTH+1; pointers wrap from FIFO_DEPTH-1 to 0.
REQ-016 SHALL drive full and empty combinationally from the count: full = (count == FIFO_DEPTH), empty = (count == 0).
REQ-017 SHALL accept a write on a rising edge when wr_en=1 and full=0: store wr_data at the write pointer, advance the write pointer.
REQ-018 SHALL reject a write when wr_en=1 and full=1 with no read that cycle: storage, pointers and count unchanged; wr_err=1 for the following cycle.
REQ-019 SHALL accept a read on a rising edge when rd_en=1 and empty=0: load rd_data with the entry at the read pointer, advance the read pointer; read latency is 1 clock.
REQ-020 SHALL reject a read when rd_en=1 and empty=1: rd_data loads 0, pointers and count unchanged, rd_err=1 for the following cycle.
REQ-021 SHALL hold rd_data unchanged in cycles with rd_en=0.
REQ-022 SHALL clear wr_err and rd_err to 0 on any edge where the corresponding operation is not rejected; each flag is a one-cycle pulse per rejected request.
REQ-023 SHALL, on simultaneous wr_en=1 and rd_en=1 with 0 < count < FIFO_DEPTH, perform both; count unchanged.
REQ-024 SHALL, on simultaneous wr_en=1 and rd_en=1 while full, perform both (read frees the slot); no wr_err; count stays FIFO_DEPTH.
REQ-025 SHALL, on simultaneous wr_en=1 and rd_en=1 while empty, accept the write and reject the read per REQ-020; count becomes 1.
REQ-026 SHALL update count +1 on write-only accept, -1 on read-only accept, unchanged otherwise.

Reset
REQ-027 SHALL, while rst_n=1, asynchronously set both pointers and count to 0, rd_data to 0, wr_err and rd_err to 0; thus empty=1, full=0.
REQ-028 SHALL not reset storage contents; reset mid-operation discards all queued data.
REQ-029 SHALL resume normal operation on the first rising edge after rst_n returns to 0.

Verification
REQ-030 Reset, then check idle outputs -> empty=1, full=0, wr_err=0, rd_err=0, rd_data=0.
REQ-031 Write 1..10 as single-cycle wr_en pulses -> full=1 after the 8th write; writes 9 and 10 each produce a one-cycle wr_err=1; contents unchanged.
REQ-032 Then ten single-cycle rd_en pulses -> rd_data after each read = 1,2,...,8, then 0, 0; empty=1 after the 8th read; reads 9 and 10 each produce a one-cycle rd_err=1.
REQ-033 Fill to 8 entries, then assert wr_en and rd_en together -> rd_data = oldest word, new word stored, full stays 1, wr_err=0.
REQ-034 From empty, assert wr_en and rd_en together with wr_data=0xA5 -> rd_err=1, rd_data=0, count=1; next read returns 0xA5.
REQ-035 Write 3 words, assert reset mid-stream -> empty=1 immediately (asynchronous); a subsequent read gives rd_err=1, rd_data=0.
